// File: rtl/qtree_mm_writer.sv
// qtree_mm_writer: writer end of the per-level mm_ram_* ports of the qtree lookup levels.
// A batch of node-write commands is accepted over valid/ready only while the lookup
// pipeline is held and drained, so lookups never observe a half-updated tree.
// Optional build macro: QTREE_MM_WRITER_ORDER_CHECK_EN adds an l <= m <= r key-order check.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no batch; hold released, not ready
// HOLD   | hold asserted, waiting for lookup_idle_i before taking commands
// WRITE  | hold asserted, ready; one RAM strobe per accepted command
// DRAIN  | one cycle after the last accept so the final RAM write lands
module qtree_mm_writer #(
    parameter int LEVEL_CNT  = 4,
    parameter int KEY_WIDTH  = 16,
    parameter int LVL_WIDTH  = 2,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [LVL_WIDTH-1:0]   cmd_level_i,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr_i,
    input  logic [KEY_WIDTH-1:0]   cmd_key_l_i,
    input  logic [KEY_WIDTH-1:0]   cmd_key_m_i,
    input  logic [KEY_WIDTH-1:0]   cmd_key_r_i,
    input  logic                   cmd_last_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    output logic                   lookup_hold_o,
    input  logic                   lookup_idle_i,
    output logic [3*KEY_WIDTH-1:0] mm_ram_data_o,
    output logic [ADDR_WIDTH-1:0]  mm_ram_addr_o,
    output logic [LEVEL_CNT-1:0]   mm_ram_write_o,
    output logic                   err_o,
    output logic [15:0]            wr_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD  = 2'd1,
        S_WRITE = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t               state;
    logic                 cmd_legal;
    logic [LEVEL_CNT-1:0] lvl_onehot;
    int                   addr_lim;
    logic                 cmd_accept;

    // ready is registered and only high in WRITE, so it doubles as the accept qualifier
    assign cmd_accept = cmd_valid_i & cmd_ready_o;

    // Decode the target level into its write strobe; out-of-range levels decode to none
    always_comb begin
        lvl_onehot = '0;
        for (int k = 0; k < LEVEL_CNT; k++) begin
            if (int'(cmd_level_i) == k) lvl_onehot[k] = 1'b1;
        end
    end

    // Legality: level in range, address fits the level RAM (width max(1, 2*level)), optional key order
    always_comb begin
        cmd_legal = 1'b1;
        addr_lim  = (cmd_level_i == '0) ? 1 : 2 * int'(cmd_level_i);
        if (int'(cmd_level_i) >= LEVEL_CNT) cmd_legal = 1'b0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            if ((i >= addr_lim) && cmd_addr_i[i]) cmd_legal = 1'b0;
        end
`ifdef QTREE_MM_WRITER_ORDER_CHECK_EN
        if (!((cmd_key_l_i <= cmd_key_m_i) && (cmd_key_m_i <= cmd_key_r_i))) cmd_legal = 1'b0;
`endif
    end

    // Batch sequencer with registered handshake, hold, RAM strobe, error pulse and write counter
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= S_IDLE;
            cmd_ready_o    <= 1'b0;
            lookup_hold_o  <= 1'b0;
            mm_ram_data_o  <= '0;
            mm_ram_addr_o  <= '0;
            mm_ram_write_o <= '0;
            err_o          <= 1'b0;
            wr_cnt_o       <= '0;
        end else begin
            mm_ram_write_o <= '0;
            err_o          <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        state         <= S_HOLD;
                        lookup_hold_o <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (lookup_idle_i) begin
                        state       <= S_WRITE;
                        cmd_ready_o <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (cmd_accept) begin
                        if (cmd_legal) begin
                            mm_ram_write_o <= lvl_onehot;
                            mm_ram_addr_o  <= cmd_addr_i;
                            mm_ram_data_o  <= {cmd_key_l_i, cmd_key_m_i, cmd_key_r_i};
                            if (wr_cnt_o != 16'hFFFF) wr_cnt_o <= wr_cnt_o + 16'd1;
                        end else begin
                            err_o <= 1'b1;
                        end
                        // illegal commands still close the batch
                        if (cmd_last_i) begin
                            state       <= S_DRAIN;
                            cmd_ready_o <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    state         <= S_IDLE;
                    lookup_hold_o <= 1'b0;
                end
                default: begin
                    state         <= S_IDLE;
                    cmd_ready_o   <= 1'b0;
                    lookup_hold_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
